// File: rtl/taxi_status_led_ctrl.sv
// taxi_status_led_ctrl
// Multi-channel board status LED controller. Each channel selects at run time
// between off, on, a shared synchronous blink, link level, link with an
// activity flash, or a stretched activity pulse. All inputs are synchronous
// to clk. Every output is registered.
//
// Ports
//   clk    : clock
//   rst_n  : asynchronous active-low reset (synchronous release expected)
//   mode   : per-channel mode, 0 OFF, 1 ON, 2 BLINK, 3 LINK, 4 LINK_ACT,
//            5 STRETCH, 6/7 reserved (treated as OFF)
//   link   : per-channel link-up level
//   act    : per-channel activity strobe, any high cycle is one event
//   tick   : one-cycle time-base pulse every CLK_FREQ_HZ/TICK_HZ cycles
//   led    : LED pin drive, lit level is !ACT_LOW
module taxi_status_led_ctrl #(
  parameter int CNT         = 4,
  parameter int CLK_FREQ_HZ = 125000000,
  parameter int TICK_HZ     = 1000,
  parameter int BLINK_TICKS = 500,
  parameter int ACT_TICKS   = 50,
  parameter bit ACT_LOW     = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CNT-1:0][2:0] mode,
  input  logic [CNT-1:0]      link,
  input  logic [CNT-1:0]      act,
  output logic                tick,
  output logic [CNT-1:0]      led
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int BW  = $clog2(BLINK_TICKS + 1);
  localparam int CW  = $clog2(ACT_TICKS + 1);

  localparam logic [PW-1:0] PRE_RELOAD = PW'(DIV - 1);
  localparam logic [PW-1:0] PRE_ONE    = PW'(1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [CW-1:0] ACT_LOAD   = CW'(ACT_TICKS);

  typedef enum logic [2:0] {
    M_OFF      = 3'd0,
    M_ON       = 3'd1,
    M_BLINK    = 3'd2,
    M_LINK     = 3'd3,
    M_LINK_ACT = 3'd4,
    M_STRETCH  = 3'd5
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DARK,
    S_LIT
  } state_t;

  logic [PW-1:0]      pre_cnt;
  logic               tick_now;
  logic [BW-1:0]      blink_cnt;
  logic               blink_phase;
  logic [CNT-1:0][2:0] mode_q;
  logic [CNT-1:0]     mode_chg;
  state_t             st  [CNT];
  logic [CW-1:0]      cnt [CNT];
  logic [CNT-1:0]     lit;
  state_t             eff;

  // tick_now marks the edge on which the registered tick output rises, so
  // the blink counter and channel FSMs advance on the same edge as tick.
  always_comb begin
    tick_now = (pre_cnt == PRE_ONE);
  end

  // Prescaler: starts at 0, reloads DIV-1 on the first edge, so the first
  // tick lands DIV cycles after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      if (pre_cnt == '0) begin
        pre_cnt <= PRE_RELOAD;
      end else begin
        pre_cnt <= pre_cnt - 1'b1;
      end
      tick <= tick_now;
    end
  end

  // Shared blink time base, common to every BLINK channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (tick_now) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    mode_chg = '0;
    for (int unsigned i = 0; i < CNT; i++) begin
      mode_chg[i] = (mode[i] != mode_q[i]);
    end
  end

  // Lit level. On a mode-change cycle the FSM is treated as IDLE so a stale
  // state from the previous mode never shows on the pin.
  always_comb begin
    lit = '0;
    eff = S_IDLE;
    for (int unsigned i = 0; i < CNT; i++) begin
      eff = mode_chg[i] ? S_IDLE : st[i];
      case (mode[i])
        M_ON:       lit[i] = 1'b1;
        M_BLINK:    lit[i] = blink_phase;
        M_LINK:     lit[i] = link[i];
        M_LINK_ACT: lit[i] = link[i] && (eff == S_IDLE || eff == S_LIT);
        M_STRETCH:  lit[i] = (eff == S_LIT);
        default:    lit[i] = 1'b0;
      endcase
    end
  end

  // Per-channel FSMs and registered LED drive. A phase ends on the tick
  // after cnt has reached 0, giving ACT_TICKS..ACT_TICKS+1 tick periods.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= '0;
      led    <= {CNT{ACT_LOW}};
      for (int unsigned i = 0; i < CNT; i++) begin
        st[i]  <= S_IDLE;
        cnt[i] <= '0;
      end
    end else begin
      mode_q <= mode;
      led    <= lit ^ {CNT{ACT_LOW}};
      for (int unsigned i = 0; i < CNT; i++) begin
        if (mode_chg[i]) begin
          st[i]  <= S_IDLE;
          cnt[i] <= '0;
        end else begin
          case (mode[i])
            M_LINK_ACT: begin
              if (!link[i]) begin
                st[i]  <= S_IDLE;
                cnt[i] <= '0;
              end else begin
                case (st[i])
                  S_IDLE: begin
                    if (act[i]) begin
                      st[i]  <= S_DARK;
                      cnt[i] <= ACT_LOAD;
                    end
                  end
                  S_DARK: begin
                    if (tick_now) begin
                      if (cnt[i] == '0) begin
                        st[i]  <= S_LIT;
                        cnt[i] <= ACT_LOAD;
                      end else begin
                        cnt[i] <= cnt[i] - 1'b1;
                      end
                    end
                  end
                  S_LIT: begin
                    if (tick_now) begin
                      if (cnt[i] == '0) begin
                        st[i] <= S_IDLE;
                      end else begin
                        cnt[i] <= cnt[i] - 1'b1;
                      end
                    end
                  end
                  default: begin
                    st[i]  <= S_IDLE;
                    cnt[i] <= '0;
                  end
                endcase
              end
            end
            M_STRETCH: begin
              // Retrigger reload wins over both decrement and expiry.
              if (act[i]) begin
                st[i]  <= S_LIT;
                cnt[i] <= ACT_LOAD;
              end else if (st[i] == S_LIT) begin
                if (tick_now) begin
                  if (cnt[i] == '0) begin
                    st[i] <= S_IDLE;
                  end else begin
                    cnt[i] <= cnt[i] - 1'b1;
                  end
                end
              end else begin
                st[i]  <= S_IDLE;
                cnt[i] <= '0;
              end
            end
            default: begin
              st[i]  <= S_IDLE;
              cnt[i] <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_taxi_status_led_ctrl.sv
// Directed bench for taxi_status_led_ctrl: DIV=10, BLINK_TICKS=3, ACT_TICKS=2,
// ACT_LOW=1, CNT=4. Edge k is the k-th rising clk edge after reset release;
// outputs are sampled 1 time unit after that edge.
module tb_taxi_status_led_ctrl;

  logic            clk;
  logic            rst_n;
  logic [3:0][2:0] mode;
  logic [3:0]      link;
  logic [3:0]      act;
  logic            tick;
  logic [3:0]      led;

  int total;
  int bad;

  taxi_status_led_ctrl #(
    .CNT        (4),
    .CLK_FREQ_HZ(1000),
    .TICK_HZ    (100),
    .BLINK_TICKS(3),
    .ACT_TICKS  (2),
    .ACT_LOW    (1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mode (mode),
    .link (link),
    .act  (act),
    .tick (tick),
    .led  (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic exp_tick;
    mode = '0; link = '0; act = '0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (led !== 4'hF) begin
      $display("FAIL reset_led got=%h exp=%h", led, 4'hF); bad++;
    end
    total++;
    if (tick !== 1'b0) begin
      $display("FAIL reset_tick got=%b exp=0", tick); bad++;
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      step();
      exp_tick = (k % 10 == 0);
      total++;
      if (tick !== exp_tick) begin
        $display("FAIL tick_k%0d got=%b exp=%b", k, tick, exp_tick); bad++;
      end
      total++;
      if (led !== 4'hF) begin
        $display("FAIL off_led_k%0d got=%h exp=%h", k, led, 4'hF); bad++;
      end
    end
  endtask

  task automatic test_blink();
    logic [3:0] exp;
    mode = {4{3'd2}}; link = '0; act = '0;
    do_reset();
    for (int k = 1; k <= 65; k++) begin
      step();
      exp = (k >= 31 && k <= 60) ? 4'h0 : 4'hF;
      total++;
      if (led !== exp) begin
        $display("FAIL blink_k%0d got=%h exp=%h", k, led, exp); bad++;
      end
    end
  endtask

  task automatic test_static_modes();
    logic [3:0] exp;
    mode[0] = 3'd0; mode[1] = 3'd1; mode[2] = 3'd3; mode[3] = 3'd6;
    link = 4'hF; act = 4'hF;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      link[2] = (k >= 4) ? 1'b0 : 1'b1;
      step();
      exp = {1'b1, (k >= 4) ? 1'b1 : 1'b0, 1'b0, 1'b1};
      total++;
      if (led !== exp) begin
        $display("FAIL static_k%0d got=%h exp=%h", k, led, exp); bad++;
      end
    end
    act = '0;
  endtask

  task automatic test_link_act();
    logic e0;
    mode = {4{3'd4}}; link = 4'hF; act = '0;
    do_reset();
    for (int k = 1; k <= 90; k++) begin
      act[0]  = (k == 12 || k == 25 || k == 55 || k == 65 || k == 72);
      link[0] = (k == 85 || k == 86) ? 1'b0 : 1'b1;
      step();
      if (k <= 12)      e0 = 1'b0;
      else if (k <= 40) e0 = 1'b1;
      else if (k <= 72) e0 = 1'b0;
      else if (k <= 86) e0 = 1'b1;
      else              e0 = 1'b0;
      total++;
      if (led !== {3'b000, e0}) begin
        $display("FAIL link_act_k%0d got=%h exp=%h", k, led, {3'b000, e0}); bad++;
      end
    end
    act = '0; link = 4'hF;
  endtask

  task automatic test_stretch();
    logic e1;
    mode = {4{3'd5}}; link = '0; act = '0;
    do_reset();
    for (int k = 1; k <= 95; k++) begin
      act[1] = (k == 5 || k == 20 || k == 35 || k == 50 || k == 65);
      step();
      e1 = (k >= 6 && k <= 90) ? 1'b0 : 1'b1;
      total++;
      if (led !== {2'b11, e1, 1'b1}) begin
        $display("FAIL stretch_k%0d got=%h exp=%h", k, led, {2'b11, e1, 1'b1}); bad++;
      end
    end
    act = '0;
  endtask

  task automatic test_mode_change();
    logic e2;
    logic e3;
    mode = {4{3'd5}}; link = 4'hF; act = '0;
    do_reset();
    for (int k = 1; k <= 25; k++) begin
      act[2]  = (k == 5);
      act[3]  = (k == 5 || k == 9);
      mode[3] = (k >= 8) ? 3'd4 : 3'd5;
      mode[2] = (k >= 15 && k <= 17) ? 3'd1 : 3'd5;
      step();
      e2 = (k >= 6 && k <= 17) ? 1'b0 : 1'b1;
      e3 = (k >= 6 && k <= 9) ? 1'b0 : 1'b1;
      total++;
      if (led !== {e3, e2, 2'b11}) begin
        $display("FAIL mode_chg_k%0d got=%h exp=%h", k, led, {e3, e2, 2'b11}); bad++;
      end
    end
    act = '0;
  endtask

  task automatic test_async_reset();
    logic exp_tick;
    mode = {4{3'd5}}; link = '0; act = '0;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      act = (k == 3) ? 4'hF : 4'h0;
      step();
    end
    total++;
    if (led !== 4'h0) begin
      $display("FAIL async_pre_led got=%h exp=%h", led, 4'h0); bad++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (led !== 4'hF) begin
      $display("FAIL async_led got=%h exp=%h", led, 4'hF); bad++;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      exp_tick = (k == 10);
      total++;
      if (led !== 4'hF || tick !== exp_tick) begin
        $display("FAIL async_after_k%0d got led=%h tick=%b exp led=%h tick=%b",
                 k, led, tick, 4'hF, exp_tick); bad++;
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    mode  = '0;
    link  = '0;
    act   = '0;
    test_reset();
    test_blink();
    test_static_modes();
    test_link_act();
    test_stretch();
    test_mode_change();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
